// File: rtl/uart_pwm_pkg.sv
// Shared types and constants for the UART-to-PWM command path.
package uart_pwm_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GET_CH   = 2'd1,
      GET_DUTY = 2'd2,
      GET_CHK  = 2'd3
   } pkt_state_e;

   localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
   localparam int unsigned PKT_LEN           = 4;

   // Expected checksum byte for a packet carrying ch and val.
   function automatic logic [7:0] pkt_chk(input logic [7:0] ch,
                                          input logic [7:0] val,
                                          input logic [7:0] sync = SYNC_BYTE_DEFAULT);
      return sync ^ ch ^ val;
   endfunction

endpackage

// File: rtl/pkt_timeout_ctr.sv
// Idle-cycle counter: clears on clr, counts while en, flags LIMIT-1 reached.
module pkt_timeout_ctr #(
   parameter int unsigned LIMIT = 100000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

   logic [CW-1:0] cnt;

   // Count idle cycles; hold at the terminal value so it never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + CW'(1);
      end
   end

   assign expired = (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/uart_pkt_decoder.sv
// Frames UART bytes into SYNC/CH/DUTY/CHK packets and issues duty writes.
module uart_pkt_decoder
   import uart_pwm_pkg::*;
#(
   parameter int unsigned NUM_CH         = 9,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   input  logic       rx_frame_err,
   output logic       duty_we,
   output logic [3:0] duty_ch,
   output logic [7:0] duty_val,
   output logic       pkt_err,
   output logic [3:0] pkt_count,
   output logic       busy
);

   pkt_state_e state_q, state_d;
   logic [7:0] ch_q, ch_d;
   logic [7:0] val_q, val_d;
   logic       we_d, err_d;
   logic [3:0] duty_ch_d;
   logic [7:0] duty_val_d;
   logic [3:0] count_d;
   logic       expired;
   logic       pkt_good;

   // Idle timer runs only while a packet is in progress.
   pkt_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (rx_valid || (state_q == IDLE)),
      .en      (state_q != IDLE),
      .expired (expired)
   );

   // Full 8-bit channel compare so out-of-range IDs never alias.
   assign pkt_good = (rx_data == pkt_chk(ch_q, val_q, SYNC_BYTE)) &&
                     (32'(ch_q) < NUM_CH);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and next-output decode; a byte always beats the timeout.
   always_comb begin
      state_d    = state_q;
      ch_d       = ch_q;
      val_d      = val_q;
      we_d       = 1'b0;
      err_d      = 1'b0;
      duty_ch_d  = duty_ch;
      duty_val_d = duty_val;
      count_d    = pkt_count;
      if (rx_valid) begin
         if (rx_frame_err) begin
            if (state_q != IDLE) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
         end else begin
            case (state_q)
               IDLE: begin
                  if (rx_data == SYNC_BYTE) begin
                     state_d = GET_CH;
                  end
               end
               GET_CH: begin
                  ch_d    = rx_data;
                  state_d = GET_DUTY;
               end
               GET_DUTY: begin
                  val_d   = rx_data;
                  state_d = GET_CHK;
               end
               GET_CHK: begin
                  state_d = IDLE;
                  if (pkt_good) begin
                     we_d       = 1'b1;
                     duty_ch_d  = ch_q[3:0];
                     duty_val_d = val_q;
                     count_d    = pkt_count + 4'd1;
                  end else begin
                     err_d = 1'b1;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end else if (expired && (state_q != IDLE)) begin
         state_d = IDLE;
         err_d   = 1'b1;
      end
   end

   // Packet fields and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ch_q      <= '0;
         val_q     <= '0;
         duty_we   <= 1'b0;
         pkt_err   <= 1'b0;
         duty_ch   <= '0;
         duty_val  <= '0;
         pkt_count <= '0;
      end else begin
         ch_q      <= ch_d;
         val_q     <= val_d;
         duty_we   <= we_d;
         pkt_err   <= err_d;
         duty_ch   <= duty_ch_d;
         duty_val  <= duty_val_d;
         pkt_count <= count_d;
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: doc/uart_pkt_decoder.md
# uart_pkt_decoder

Byte-level packet parser between the UART receiver and the PWM duty register bank in the uart_pwm_top datapath. It consumes received bytes, frames them into fixed 4-byte command packets, validates the checksum and channel, and issues one duty-cycle write strobe per good packet. It also maintains the 4-bit packet counter shown on the seven-segment display.

## Interface
Parameters:
- NUM_CH, 9: number of PWM channels; valid channel IDs are 0..NUM_CH-1.
- TIMEOUT_CYCLES, 100000: maximum idle clk cycles between bytes of one packet before the packet is abandoned.
- SYNC_BYTE, 8'hA5: packet start marker.

Ports:
- clk, input, 1: system clock. One clock domain for the whole block.
- rst_n, input, 1: reset, asynchronous, active-low.
- rx_valid, input, 1: one-cycle pulse; rx_data holds a received byte.
- rx_data, input, 8: received byte, valid only when rx_valid=1.
- rx_frame_err, input, 1: one-cycle pulse; the UART detected a bad stop bit on the current byte.
- duty_we, output, 1: one-cycle write strobe to the duty register bank.
- duty_ch, output, 4: channel index, valid while duty_we=1.
- duty_val, output, 8: duty value, valid while duty_we=1.
- pkt_err, output, 1: one-cycle pulse when a packet is rejected.
- pkt_count, output, 4: count of good packets, wraps modulo 16.
- busy, output, 1: high whenever the FSM is not in IDLE.

## Operation
- Packet format: SYNC, CH, DUTY, CHK, where CHK = SYNC ^ CH ^ DUTY.
- FSM states: IDLE, GET_CH, GET_DUTY, GET_CHK. All transitions occur only on cycles with rx_valid=1, except timeout and reset.
  - IDLE: byte == SYNC_BYTE goes to GET_CH. Any other byte is dropped silently, with no pkt_err.
  - GET_CH: latch the byte into ch_r, then go to GET_DUTY.
  - GET_DUTY: latch the byte into val_r, then go to GET_CHK.
  - GET_CHK: a packet is good when the byte equals SYNC_BYTE^ch_r^val_r and ch_r < NUM_CH.
    - Good: issue the write, increment pkt_count, go to IDLE.
    - Bad: pulse pkt_err, go to IDLE.
- Inside a packet, a SYNC_BYTE value is ordinary data. There is no resynchronisation mid-packet.
- rx_frame_err together with rx_valid:
  - In IDLE: the byte is ignored.
  - In any other state: abort to IDLE and pulse pkt_err. The byte is not used.
- Timeout:
  - An idle counter clears on every rx_valid and whenever the FSM is in IDLE. Otherwise it increments.
  - When the counter reaches TIMEOUT_CYCLES-1 with no rx_valid, the FSM returns to IDLE and pulses pkt_err.
  - If rx_valid arrives on the same cycle as the timeout, the byte wins: it is processed normally and no timeout occurs.
- The counter width is $clog2(TIMEOUT_CYCLES). The compare is unsigned.
- pkt_count wraps from 15 to 0 with no saturation.
- duty_ch takes the low 4 bits of ch_r. The ch_r < NUM_CH compare uses the full 8 bits, so a CH value of 0x10 is rejected and does not alias to channel 0.

## Timing
- Reset values of all outputs: duty_we=0, duty_ch=0, duty_val=0, pkt_err=0, pkt_count=0, busy=0. The FSM resets to IDLE and all internal registers reset to 0.
- Latency: duty_we, duty_ch and duty_val are registered and assert exactly 1 cycle after the clk edge that samples a valid CHK byte. pkt_count updates on that same edge.
- duty_ch and duty_val hold their values until the next good packet.
- pkt_err: registered, 1 cycle after the rejecting event.
- duty_we and pkt_err are never high in the same cycle.
- Back-to-back packets are supported. A SYNC byte arriving on the cycle immediately after CHK is accepted.
- No backpressure: every rx_valid byte is consumed in the cycle it is presented.
- Reset asserted mid-packet: all state clears asynchronously. The partial packet is discarded and no pkt_err is issued.

## Structure
- Shared package uart_pwm_pkg holds:
  - the FSM state enum (IDLE, GET_CH, GET_DUTY, GET_CHK);
  - the SYNC_BYTE default constant;
  - the PKT_LEN=4 constant;
  - a function pkt_chk(ch, val) that returns SYNC_BYTE^ch^val.
- One sub-module, pkt_timeout_ctr: a parameterised idle counter with inputs clr and en and output expired. It is instantiated once.
- Everything else is a single FSM plus registered output logic in uart_pkt_decoder.

## Test plan
- Good packet: bytes A5,03,80,26 → one duty_we pulse 1 cycle after the CHK byte with duty_ch=3 and duty_val=0x80; pkt_count goes 0→1; pkt_err stays 0.
- Bad checksum: bytes A5,03,80,27 → one pkt_err pulse, no duty_we, pkt_count unchanged. Then a good packet A5,00,FF,5A → duty_ch=0, duty_val=FF.
- Noise and invalid channel:
  - Bytes 00,FF,12 in IDLE → no outputs and busy=0.
  - Bytes A5,09,10,BC with NUM_CH=9 → pkt_err pulse, no write.
  - Bytes A5,10,00,B5 → rejected (no alias to channel 0).
- Timeout and frame error:
  - With TIMEOUT_CYCLES=16, send A5,02 and then idle for 15 cycles → pkt_err pulse and busy=0.
  - A subsequent A5 with rx_frame_err=1 → ignored.
  - A5,01 followed by a frame-error byte → pkt_err.
- Wrap and back-to-back: 17 consecutive good packets with no gap → 17 duty_we pulses and final pkt_count=1.
- Async reset: assert rst_n=0 after the DUTY byte → all outputs are 0 immediately, and no write occurs after release.
